// File: rtl/riscv_defs.sv
// Shared widths and fetch FSM state encoding for the instruction front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_defs;

   localparam int NB_WORD = 32;
   localparam int NB_ADDR = 32;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {addr+4, instruction} entries for decode.
// Latency: head visible combinationally the cycle after the push edge.
// Backpressure: push accepted when not full, or when full with a same-cycle pop.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int CW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CW:0]      wr_ptr;
   logic [CW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count    = wr_ptr - rd_ptr;
   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[CW-1:0]];

   // Pointer update; a flush wins over any push or pop in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clock) begin
      if (do_push && !clear) mem[wr_ptr[CW-1:0]] <= push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order memory reads, buffers responses, hands them to decode.
// Latency: first instruction two edges after a redirect with single-cycle memory.
// Backpressure: stops requesting once outstanding + buffered reaches FB_DEPTH; holds head while i_ready low.
module fetch_unit
   import riscv_defs::*;
#(
   parameter logic [NB_ADDR-1:0] RESET_PC = 32'h0000_0000,
   parameter int                 FB_DEPTH = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   output logic               o_imem_req,
   output logic [NB_ADDR-1:0] o_imem_addr,
   input  logic               i_imem_gnt,
   input  logic               i_imem_rvalid,
   input  logic [NB_WORD-1:0] i_imem_rdata,
   input  logic               i_redirect,
   input  logic [NB_ADDR-1:0] i_redirect_addr,
   output logic               o_valid,
   input  logic               i_ready,
   output logic [NB_WORD-1:0] o_instruction,
   output logic [NB_WORD-1:0] o_pc,
   output logic               o_fault
);

   localparam int            CW      = $clog2(FB_DEPTH);
   localparam logic [CW+1:0] DEPTH_W = (CW+2)'(FB_DEPTH);

   fetch_state_t              state;
   fetch_state_t              state_next;
   logic [NB_ADDR-1:0]        pc;
   logic [NB_ADDR-1:0]        rsp_pc;
   logic [CW:0]               outstanding;
   logic [CW:0]               out_next;
   logic [CW:0]               drop_cnt;
   logic [CW:0]               fb_count;
   logic                      ignore_rsp;
   logic                      redirect_ok;
   logic                      redirect_bad;
   logic                      grant;
   logic                      rsp_live;
   logic                      push;
   logic                      pop;
   logic                      fb_full;
   logic                      fb_empty;
   logic [NB_ADDR+NB_WORD-1:0] head;

   assign redirect_ok  = (state == RUN) && i_redirect && (i_redirect_addr[1:0] == 2'b00);
   assign redirect_bad = (state == RUN) && i_redirect && (i_redirect_addr[1:0] != 2'b00);

   // Credit check counts responses still owed to us, including ones that will be dropped.
   assign o_imem_req  = (state == RUN) && !i_redirect &&
                        (({1'b0, outstanding} + {1'b0, fb_count}) < DEPTH_W);
   assign o_imem_addr = pc;
   assign grant       = o_imem_req && i_imem_gnt;

   // Responses seen before the first post-reset grant belong to a previous life.
   assign rsp_live = i_imem_rvalid && !ignore_rsp;
   assign push     = rsp_live && (state == RUN) && !i_redirect && (drop_cnt == '0) &&
                     (!fb_full || pop);

   assign o_valid       = (state == RUN) && !fb_empty && !i_redirect;
   assign pop           = o_valid && i_ready;
   assign o_pc          = head[NB_ADDR+NB_WORD-1:NB_WORD];
   assign o_instruction = head[NB_WORD-1:0];
   assign o_fault       = (state == HALT);

   fetch_fifo #(
      .DEPTH (FB_DEPTH),
      .WIDTH (NB_ADDR+NB_WORD)
   ) u_fifo (
      .clock     (i_clock),
      .reset     (i_reset),
      .clear     ((state == RUN) && i_redirect),
      .push      (push),
      .push_data ({rsp_pc + NB_ADDR'(4), i_imem_rdata}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fb_full),
      .empty     (fb_empty),
      .count     (fb_count)
   );

   // Next-state: one boot cycle, then run until a misaligned redirect halts for good.
   always_comb begin
      state_next = state;
      case (state)
         BOOT:    state_next = RUN;
         RUN:     if (redirect_bad) state_next = HALT;
         HALT:    state_next = HALT;
         default: state_next = BOOT;
      endcase
   end

   // In-flight count after this cycle's grant and response.
   always_comb begin
      out_next = outstanding;
      if (grant) out_next = out_next + 1'b1;
      if (rsp_live && (outstanding != '0)) out_next = out_next - 1'b1;
   end

   // State, fetch/response PCs and in-flight bookkeeping.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         ignore_rsp  <= 1'b1;
      end else begin
         state       <= state_next;
         outstanding <= out_next;
         if (grant) ignore_rsp <= 1'b0;

         if (redirect_ok) pc <= i_redirect_addr;
         else if (grant)  pc <= pc + NB_ADDR'(4);

         // Every accepted response is sequential from the last redirect target.
         if (redirect_ok) rsp_pc <= i_redirect_addr;
         else if (push)   rsp_pc <= rsp_pc + NB_ADDR'(4);

         // Everything still in flight at a redirect is stale.
         if (redirect_ok)                         drop_cnt <= out_next;
         else if (rsp_live && (drop_cnt != '0))   drop_cnt <= drop_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a sequential-address memory/decode model.
// Latency: n/a.
// Backpressure: exercised through random i_ready and random grants.
module tb_fetch_unit;

   logic        i_clock;
   logic        i_reset;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        i_redirect;
   logic [31:0] i_redirect_addr;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;
   logic        o_fault;

   logic        w_req, w_gnt, w_rvalid, w_redirect, w_valid, w_ready, w_fault;
   logic [31:0] w_addr, w_rdata, w_redirect_addr, w_ins, w_pc;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int redir_cyc = 0;
   bit rand_gnt = 0;
   bit inject_stale = 0;
   int lat_min = 1;
   int lat_max = 1;
   int last_due = 0;

   logic [31:0] exp_req = 32'h0;
   logic [31:0] exp_del = 32'h0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] grant_addr[$];
   logic [31:0] deliv_pc[$];
   logic [31:0] deliv_ins[$];
   int          deliv_cyc[$];

   fetch_unit #(.RESET_PC(32'h0000_0000), .FB_DEPTH(2)) dut (
      .i_clock(i_clock), .i_reset(i_reset),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
      .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
      .o_valid(o_valid), .i_ready(i_ready), .o_instruction(o_instruction),
      .o_pc(o_pc), .o_fault(o_fault));

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FB_DEPTH(2)) dut_wrap (
      .i_clock(i_clock), .i_reset(i_reset),
      .o_imem_req(w_req), .o_imem_addr(w_addr), .i_imem_gnt(w_gnt),
      .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
      .i_redirect(w_redirect), .i_redirect_addr(w_redirect_addr),
      .o_valid(w_valid), .i_ready(w_ready), .o_instruction(w_ins),
      .o_pc(w_pc), .o_fault(w_fault));

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   // Instruction memory contents as a pure function of the byte address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
   endfunction

   // Memory model: grants, in-order responses with random latency, request-address check.
   initial begin
      int due;
      forever begin
         @(negedge i_clock);
         cyc = cyc + 1;
         #1;
         if (!i_reset) begin
            pend_addr.delete();
            pend_due.delete();
            last_due = 0;
            i_imem_rvalid = 1'b0;
            i_imem_gnt = 1'b0;
         end else begin
            if (inject_stale) begin
               i_imem_rvalid = 1'b1;
               i_imem_rdata = 32'hDEAD_BEEF;
               inject_stale = 0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
               i_imem_rvalid = 1'b1;
               i_imem_rdata = mem_word(pend_addr.pop_front());
               void'(pend_due.pop_front());
            end else begin
               i_imem_rvalid = 1'b0;
               i_imem_rdata = $urandom;
            end
            i_imem_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         #1;
         if (i_reset && o_imem_req && i_imem_gnt) begin
            checks++;
            if (o_imem_addr !== exp_req) begin
               failures++;
               $display("FAIL req_addr: got %h expected %h (cycle %0d)", o_imem_addr, exp_req, cyc);
            end
            grant_addr.push_back(o_imem_addr);
            exp_req = exp_req + 32'd4;
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(o_imem_addr);
            pend_due.push_back(due);
         end
      end
   end

   // Decode-side monitor: every accepted instruction must be the next sequential one.
   initial begin
      forever begin
         @(negedge i_clock);
         #3;
         if (i_reset && o_valid && i_ready) begin
            checks++;
            if (o_pc !== exp_del + 32'd4 || o_instruction !== mem_word(exp_del)) begin
               failures++;
               $display("FAIL deliver: got pc %h ins %h expected pc %h ins %h", o_pc, o_instruction,
                        exp_del + 32'd4, mem_word(exp_del));
            end
            deliv_pc.push_back(o_pc);
            deliv_ins.push_back(o_instruction);
            deliv_cyc.push_back(cyc);
            exp_del = exp_del + 32'd4;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_deliv(input int target, output bit ok);
      ok = 0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge i_clock);
         #4;
         if (deliv_pc.size() >= target) ok = 1;
      end
   endtask

   // Called at a falling edge; redirects the model along with the DUT.
   task automatic do_redirect(input logic [31:0] tgt);
      i_redirect = 1'b1;
      i_redirect_addr = tgt;
      exp_req = tgt;
      exp_del = tgt;
      #4;
      redir_cyc = cyc;
      checks++;
      if (o_valid !== 1'b0 || o_imem_req !== 1'b0) begin
         failures++;
         $display("FAIL redirect_quiet: valid %b req %b expected 0 0", o_valid, o_imem_req);
      end
      @(negedge i_clock);
      i_redirect = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge i_clock);
      i_reset = 1'b0;
      rand_gnt = 0; lat_min = 1; lat_max = 1; i_ready = 1'b1; i_redirect = 1'b0;
      exp_req = 32'h0; exp_del = 32'h0;
      deliv_pc.delete(); deliv_ins.delete(); deliv_cyc.delete(); grant_addr.delete();
      #4;
      checks++;
      if (o_imem_req !== 1'b0 || o_valid !== 1'b0 || o_fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: req %b valid %b fault %b expected 0 0 0", o_imem_req, o_valid, o_fault);
      end
      repeat (2) @(negedge i_clock);
      i_reset = 1'b1;
      #4;
      checks++;
      if (o_imem_req !== 1'b0) begin
         failures++;
         $display("FAIL boot_no_req: req %b expected 0", o_imem_req);
      end
      @(negedge i_clock);
      inject_stale = 1;
      #4;
      checks++;
      if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL first_req: req %b addr %h expected 1 00000000", o_imem_req, o_imem_addr);
      end
   endtask

   task automatic test_reset;
      do_reset();
   endtask

   task automatic test_sequential;
      bit ok;
      wait_deliv(3, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL seq_timeout: deliveries %0d expected >= 3", deliv_pc.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            checks++;
            if (deliv_pc[i] !== a + 32'd4 || deliv_ins[i] !== mem_word(a) || grant_addr[i] !== a) begin
               failures++;
               $display("FAIL seq_%0d: pc %h ins %h req %h expected pc %h ins %h req %h", i,
                        deliv_pc[i], deliv_ins[i], grant_addr[i], a + 32'd4, mem_word(a), a);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      int g0, n0;
      @(negedge i_clock);
      i_ready = 1'b0;
      g0 = grant_addr.size();
      n0 = deliv_pc.size();
      repeat (9) @(negedge i_clock);
      #4;
      checks++;
      if (o_imem_req !== 1'b0 || o_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_stall: req %b valid %b expected 0 1", o_imem_req, o_valid);
      end
      checks++;
      if (grant_addr.size() - g0 > 2 || deliv_pc.size() != n0) begin
         failures++;
         $display("FAIL bp_counts: grants %0d deliveries %0d expected <=2 and 0",
                  grant_addr.size() - g0, deliv_pc.size() - n0);
      end
      @(negedge i_clock);
      i_ready = 1'b1;
      repeat (20) @(negedge i_clock);
      #4;
      checks++;
      if (deliv_pc.size() - n0 < 4) begin
         failures++;
         $display("FAIL bp_resume: deliveries %0d expected >= 4", deliv_pc.size() - n0);
      end
   endtask

   task automatic test_redirect_outstanding;
      bit found, ok;
      int n0;
      lat_min = 3; lat_max = 3;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge i_clock);
         #4;
         if (pend_due.size() == 2 && pend_due[0] > cyc + 1) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL redir_setup: never saw 2 outstanding, got %0d", pend_due.size());
      end else begin
         @(negedge i_clock);
         n0 = deliv_pc.size();
         do_redirect(32'h0000_0100);
         wait_deliv(n0 + 1, ok);
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL redir_timeout: no delivery after redirect, got %0d expected 1", deliv_pc.size() - n0);
         end else if (deliv_pc[n0] !== 32'h104 || deliv_ins[n0] !== mem_word(32'h100)) begin
            failures++;
            $display("FAIL redir_first: pc %h ins %h expected 00000104 %h", deliv_pc[n0], deliv_ins[n0],
                     mem_word(32'h100));
         end
      end
      lat_min = 1; lat_max = 1;
   endtask

   task automatic test_redirect_grant;
      bit found, ok;
      int n0, g0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge i_clock);
         if (o_imem_req === 1'b1) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL rg_setup: o_imem_req never high, got %b", o_imem_req);
      end else begin
         n0 = deliv_pc.size();
         g0 = grant_addr.size();
         do_redirect(32'h0000_0200);
         wait_deliv(n0 + 1, ok);
         checks++;
         if (!ok || grant_addr.size() <= g0) begin
            failures++;
            $display("FAIL rg_timeout: deliveries %0d grants %0d expected >=1 each",
                     deliv_pc.size() - n0, grant_addr.size() - g0);
         end else begin
            checks++;
            if (grant_addr[g0] !== 32'h200) begin
               failures++;
               $display("FAIL rg_next_req: addr %h expected 00000200", grant_addr[g0]);
            end
            checks++;
            if (deliv_pc[n0] !== 32'h204 || deliv_cyc[n0] < redir_cyc + 3) begin
               failures++;
               $display("FAIL rg_first: pc %h after %0d cycles expected 00000204 after >= 3",
                        deliv_pc[n0], deliv_cyc[n0] - redir_cyc);
            end
         end
      end
   endtask

   task automatic test_random;
      int n0;
      n0 = deliv_pc.size();
      rand_gnt = 1; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 1500; i++) begin
         @(negedge i_clock);
         i_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 40) == 0) do_redirect($urandom & 32'h0000_FFFC);
      end
      rand_gnt = 0; lat_min = 1; lat_max = 1;
      @(negedge i_clock);
      i_ready = 1'b1;
      repeat (10) @(negedge i_clock);
      #4;
      checks++;
      if (deliv_pc.size() - n0 < 100) begin
         failures++;
         $display("FAIL rand_throughput: deliveries %0d expected >= 100", deliv_pc.size() - n0);
      end
   endtask

   task automatic test_fault;
      bit ok;
      @(negedge i_clock);
      i_redirect = 1'b1;
      i_redirect_addr = 32'h0000_0102;
      #4;
      checks++;
      if (o_valid !== 1'b0 || o_imem_req !== 1'b0) begin
         failures++;
         $display("FAIL fault_cycle: valid %b req %b expected 0 0", o_valid, o_imem_req);
      end
      @(negedge i_clock);
      i_redirect = 1'b0;
      #4;
      checks++;
      if (o_fault !== 1'b1 || o_imem_req !== 1'b0 || o_valid !== 1'b0) begin
         failures++;
         $display("FAIL fault_rise: fault %b req %b valid %b expected 1 0 0", o_fault, o_imem_req, o_valid);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clock);
         i_ready = $urandom_range(0, 1);
         i_redirect = (i == 3);
         i_redirect_addr = 32'h0000_0300;
         #4;
         checks++;
         if (o_fault !== 1'b1 || o_imem_req !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_hold_%0d: fault %b req %b valid %b expected 1 0 0", i, o_fault, o_imem_req, o_valid);
         end
      end
      i_redirect = 1'b0;
      do_reset();
      wait_deliv(1, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL fault_recover: deliveries %0d expected 1", deliv_pc.size());
      end else if (deliv_pc[0] !== 32'h4 || deliv_ins[0] !== mem_word(32'h0)) begin
         failures++;
         $display("FAIL fault_recover: pc %h ins %h expected 00000004 %h", deliv_pc[0], deliv_ins[0], mem_word(32'h0));
      end
   endtask

   task automatic test_wrap;
      logic [31:0] wa[$];
      logic [31:0] wp[$];
      logic [31:0] wi[$];
      bit          last_g;
      logic [31:0] last_a;
      @(negedge i_clock);
      #4;
      checks++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
         failures++;
         $display("FAIL wrap_first_req: req %b addr %h expected 1 fffffffc", w_req, w_addr);
      end
      last_g = 0;
      last_a = 32'h0;
      for (int i = 0; i < 8; i++) begin
         @(negedge i_clock);
         w_rvalid = last_g;
         w_rdata = mem_word(last_a);
         w_gnt = 1'b1;
         #2;
         last_g = w_req;
         last_a = w_addr;
         if (w_req) wa.push_back(w_addr);
         #2;
         if (w_valid) begin
            wp.push_back(w_pc);
            wi.push_back(w_ins);
         end
      end
      w_gnt = 1'b0;
      w_rvalid = 1'b0;
      checks++;
      if (wa.size() < 2) begin
         failures++;
         $display("FAIL wrap_reqs: %0d requests expected >= 2", wa.size());
      end else if (wa[0] !== 32'hFFFF_FFFC || wa[1] !== 32'h0) begin
         failures++;
         $display("FAIL wrap_reqs: %h %h expected fffffffc 00000000", wa[0], wa[1]);
      end
      checks++;
      if (wp.size() < 1) begin
         failures++;
         $display("FAIL wrap_pc: no instruction delivered, expected pc 00000000");
      end else if (wp[0] !== 32'h0 || wi[0] !== mem_word(32'hFFFF_FFFC)) begin
         failures++;
         $display("FAIL wrap_pc: pc %h ins %h expected 00000000 %h", wp[0], wi[0], mem_word(32'hFFFF_FFFC));
      end
   endtask

   initial begin
      i_reset = 1'b0;
      i_redirect = 1'b0;
      i_redirect_addr = 32'h0;
      i_ready = 1'b1;
      i_imem_gnt = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata = 32'h0;
      w_gnt = 1'b0;
      w_rvalid = 1'b0;
      w_rdata = 32'h0;
      w_redirect = 1'b0;
      w_redirect_addr = 32'h0;
      w_ready = 1'b1;
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect_outstanding();
      test_redirect_grant();
      test_random();
      test_fault();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FB_DEPTH, default 2: fetch buffer entries and maximum outstanding memory requests; power of two, at least 2.
REQ-003 SHALL have port i_clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port o_imem_req, output, 1 bit: instruction memory read request.
REQ-006 SHALL have port o_imem_addr, output, NB_ADDR bits: request byte address; always a multiple of 4.
REQ-007 SHALL have port i_imem_gnt, input, 1 bit: request accepted this cycle.
REQ-008 SHALL have port i_imem_rvalid, input, 1 bit: response data valid; responses return in request order, at least 1 cycle after grant.
REQ-009 SHALL have port i_imem_rdata, input, NB_WORD bits: fetched instruction.
REQ-010 SHALL have port i_redirect, input, 1 bit: driven by the branch/jump unit's taken/flush signal.
REQ-011 SHALL have port i_redirect_addr, input, NB_ADDR bits: redirect target from the branch/jump unit.
REQ-012 SHALL have port o_valid, output, 1 bit: an instruction is presented to decode.
REQ-013 SHALL have port i_ready, input, 1 bit: decode accepts the instruction when o_valid and i_ready are both high.
REQ-014 SHALL have port o_instruction, output, NB_WORD bits: instruction word.
REQ-015 SHALL have port o_pc, output, NB_WORD bits: fetch address + 4, i.e. the next-instruction address the branch/jump unit expects on its i_pc.
REQ-016 SHALL have port o_fault, output, 1 bit: misaligned redirect target; sticky until reset.

Function
REQ-017 SHALL implement FSM states BOOT, RUN and HALT: BOOT→RUN unconditionally after one cycle; RUN→HALT on i_redirect with i_redirect_addr[1:0] != 0; HALT exits only through reset.
REQ-018 SHALL assert o_imem_req only in RUN, and only when outstanding + buffered entries < FB_DEPTH and i_redirect is low.
REQ-019 SHALL increment the fetch PC by 4 on each cycle where o_imem_req and i_imem_gnt are both high, wrapping modulo 2^NB_ADDR.
REQ-020 SHALL hold o_imem_req and o_imem_addr stable while a request is not yet granted, unless a redirect occurs.
REQ-021 SHALL, on an aligned i_redirect in RUN, on the same edge: load the fetch PC with i_redirect_addr, clear the fetch buffer, and set the drop counter to the outstanding count, including any request granted that cycle.
REQ-022 SHALL discard each i_imem_rvalid response while the drop counter is non-zero and decrement the counter; otherwise it SHALL push the response with its address + 4.
REQ-023 SHALL present the fetch buffer head combinationally on o_valid, o_instruction and o_pc, with o_valid forced low in the cycle i_redirect is high.
REQ-024 SHALL pop the fetch buffer on o_valid && i_ready, and SHALL allow a push and a pop in the same cycle when the buffer is full.
REQ-025 SHALL deliver the first instruction after a redirect no earlier than 2 cycles after the redirect edge with zero-wait memory (1-cycle rvalid latency).
REQ-026 SHALL, in HALT, keep o_fault high, o_valid low and o_imem_req low, and SHALL drop all memory responses.

Reset
REQ-027 SHALL, while i_reset is low: set FSM to BOOT, fetch PC to RESET_PC, buffer empty, outstanding and drop counters to 0, and o_imem_req, o_valid and o_fault to 0.
REQ-028 SHALL, on reset asserted mid-transaction, discard in-flight responses by ignoring i_imem_rvalid until the next request is granted after reset.

Structure
REQ-029 SHALL place NB_WORD, NB_ADDR and the enum fetch_state_t {BOOT, RUN, HALT} in package riscv_defs.
REQ-030 SHALL implement the buffer as sub-module fetch_fifo, a synchronous FIFO of {addr+4, instruction} with full/empty/count outputs and the same clock/reset.

Verification
REQ-031 SHALL verify reset release with zero-wait memory: requests at 0x0, 0x4, 0x8 → o_pc sequence 0x4, 0x8, 0xC with matching rdata.
REQ-032 SHALL verify backpressure with i_ready low for 10 cycles: o_imem_req deasserts once FB_DEPTH entries are held; no instruction is lost or duplicated after i_ready rises.
REQ-033 SHALL verify a redirect to 0x100 with 2 requests outstanding: both responses are dropped, and the next o_valid shows o_pc = 0x104.
REQ-034 SHALL verify a redirect in the same cycle as a grant: the granted response is dropped, and the next request address is the redirect target.
REQ-035 SHALL verify a redirect to 0x102: o_fault rises next cycle, o_imem_req and o_valid stay low, and the state is cleared only by i_reset low.
REQ-036 SHALL verify PC wrap: RESET_PC = 0xFFFF_FFFC gives requests at 0xFFFF_FFFC then 0x0, and o_pc = 0x0 for the first instruction.
